// File: rtl/my_adder8.sv
// Registered unsigned adder with optional magnitude subtractor (enable with MY_ADDER8_SUB_EN).
// One-cycle latency; S carries the carry-out, D is |A-B|, is_negative flags A<B.
module my_adder8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH:0]   S,
  output logic [WIDTH-1:0] D,
  output logic             is_negative
);

  logic [WIDTH:0]   sum_p0;
  logic [WIDTH:0]   add_c_p0;
  logic [WIDTH:0]   s_p1;
  logic             vld_p1;

  // Stage 0: combinational ripple-carry add of the raw operands
  assign add_c_p0[0] = 1'b0;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_add
      assign sum_p0[i]     = A[i] ^ B[i] ^ add_c_p0[i];
      assign add_c_p0[i+1] = (A[i] & B[i]) | (add_c_p0[i] & (A[i] ^ B[i]));
    end
  endgenerate

  assign sum_p0[WIDTH] = add_c_p0[WIDTH];

`ifdef MY_ADDER8_SUB_EN
  logic [WIDTH-1:0] diff_p0;
  logic [WIDTH:0]   sub_c_p0;
  logic             borrow_p0;
  logic [WIDTH-1:0] mag_p0;
  logic [WIDTH-1:0] d_p1;
  logic             neg_p1;

  function automatic logic [WIDTH-1:0] twos_negate(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // A + ~B + 1 on a second full-adder chain; carry-out low means a borrow
  assign sub_c_p0[0] = 1'b1;

  for (i = 0; i < WIDTH; i++) begin : g_sub
    assign diff_p0[i]    = A[i] ^ ~B[i] ^ sub_c_p0[i];
    assign sub_c_p0[i+1] = (A[i] & ~B[i]) | (sub_c_p0[i] & (A[i] ^ ~B[i]));
  end

  assign borrow_p0 = ~sub_c_p0[WIDTH];
  assign mag_p0    = borrow_p0 ? twos_negate(diff_p0) : diff_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_p1   <= '0;
      neg_p1 <= 1'b0;
    end else if (in_valid) begin
      d_p1   <= mag_p0;
      neg_p1 <= borrow_p0;
    end
  end

  assign D           = d_p1;
  assign is_negative = neg_p1;
`else
  assign D           = '0;
  assign is_negative = 1'b0;
`endif

  // Stage 1: output registers; data holds while no new operands arrive
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      s_p1   <= '0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        s_p1 <= sum_p0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign S         = s_p1;

endmodule

// File: tb/tb_my_adder8.sv
// Scoreboard bench for my_adder8: expected results queued at drive time, popped on out_valid.
module tb_my_adder8;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] A;
  logic [7:0] B;
  logic       out_valid;
  logic [8:0] S;
  logic [7:0] D;
  logic       is_negative;

  typedef struct packed {
    logic [8:0] s;
    logic [7:0] d;
    logic       neg;
  } exp_t;

  exp_t sb[$];
  exp_t held;
  logic exp_vld = 1'b0;
  logic mon_en  = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  my_adder8 #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .A           (A),
    .B           (B),
    .out_valid   (out_valid),
    .S           (S),
    .D           (D),
    .is_negative (is_negative)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.s = {1'b0, a} + {1'b0, b};
`ifdef MY_ADDER8_SUB_EN
    e.neg = (a < b);
    e.d   = (a >= b) ? (a - b) : (b - a);
`else
    e.neg = 1'b0;
    e.d   = 8'h00;
`endif
    return e;
  endfunction

  // Apply one cycle of inputs, then update the reference model after the edge
  task automatic step(input logic r, input logic v, input logic [7:0] a, input logic [7:0] b);
    rst      = r;
    in_valid = v;
    A        = a;
    B        = b;
    @(posedge clk);
    exp_vld = v && !r;
    if (r) held = '0;
    if (v && !r) sb.push_back(model(a, b));
    #1;
    in_valid = 1'b0;
    rst      = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("out_valid", {31'b0, out_valid}, {31'b0, exp_vld});
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          held = sb.pop_front();
        end
      end
      check("S", {23'b0, S}, {23'b0, held.s});
      check("D", {24'b0, D}, {24'b0, held.d});
      check("is_negative", {31'b0, is_negative}, {31'b0, held.neg});
    end
  end

  initial begin
    held     = '0;
    rst      = 1'b1;
    in_valid = 1'b0;
    A        = 8'h00;
    B        = 8'h00;
    step(1'b1, 1'b0, 8'h00, 8'h00);
    mon_en = 1'b1;
    step(1'b1, 1'b0, 8'h00, 8'h00);

    // Max operands, then hold for three idle cycles
    step(1'b0, 1'b1, 8'hFF, 8'hFF);
    repeat (3) step(1'b0, 1'b0, 8'h00, 8'h00);

    step(1'b0, 1'b1, 8'h05, 8'h0A);
    step(1'b0, 1'b1, 8'h0A, 8'h05);
    step(1'b0, 1'b0, 8'h00, 8'h00);

    // Back-to-back accepts
    step(1'b0, 1'b1, 8'h80, 8'h80);
    step(1'b0, 1'b1, 8'h00, 8'hFF);
    step(1'b0, 1'b1, 8'h33, 8'h33);
    step(1'b0, 1'b0, 8'h00, 8'h00);

    // in_valid with reset is discarded
    step(1'b0, 1'b1, 8'hFF, 8'h01);
    step(1'b1, 1'b1, 8'h12, 8'h34);
    step(1'b0, 1'b0, 8'h00, 8'h00);

    step(1'b0, 1'b1, 8'h03, 8'h07);
    step(1'b0, 1'b0, 8'h00, 8'h00);

    // Reset the cycle after an accept wins over the held result
    step(1'b0, 1'b1, 8'hC0, 8'h41);
    step(1'b1, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 8'h00, 8'h00);

    for (int k = 0; k < 60; k++) begin
      step(1'b0, ($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    step(1'b0, 1'b1, 8'h00, 8'h00);
    step(1'b0, 1'b1, 8'h01, 8'h00);
    step(1'b0, 1'b1, 8'h00, 8'h01);
    repeat (2) step(1'b0, 1'b0, 8'h00, 8'h00);

    mon_en = 1'b0;
    check("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/my_adder8.md
MY_ADDER8 -- requirements
Module: my_adder8

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 Parameter WIDTH, default 8, SHALL set the operand width; all port widths below derive from WIDTH, and only WIDTH=8 is required to be supported.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  operands A/B are sampled this cycle when high.
REQ-006 A  input  WIDTH  unsigned operand A.
REQ-007 B  input  WIDTH  unsigned operand B.
REQ-008 out_valid  output  1  one-cycle pulse marking new results on S/D/is_negative.
REQ-009 S  output  WIDTH+1  unsigned sum A+B; the MSB is the carry-out.
REQ-010 D  output  WIDTH  magnitude of A-B.
REQ-011 is_negative  output  1  high when A<B, i.e. the true difference is negative.

Function
REQ-012 The block SHALL treat A and B as unsigned; no signed interpretation anywhere.
REQ-013 S SHALL equal A+B computed at WIDTH+1 bits with no truncation, so the maximum is 2*(2^WIDTH-1).
REQ-014 D SHALL equal A-B when A>=B and B-A when A<B, so D is never two's-complement encoded.
REQ-015 is_negative SHALL be 1 iff A<B; A==B SHALL give D=0 and is_negative=0.
REQ-016 The addition SHALL be built as an explicit ripple-carry chain of WIDTH full-adder cells (generate loop).
REQ-017 The subtraction SHALL reuse a full-adder chain computing A+~B+1; borrow is the inverted carry-out, and D is conditionally negated when borrow=1.
REQ-018 Latency SHALL be exactly 1 cycle: operands sampled on edge N with in_valid=1 SHALL appear on S/D/is_negative with out_valid=1 after edge N.
REQ-019 out_valid SHALL be high for exactly one cycle per accepted operand pair; back-to-back in_valid SHALL yield back-to-back results at full throughput.
REQ-020 When in_valid=0, S, D and is_negative SHALL hold their last values and out_valid SHALL be 0.
REQ-021 The block SHALL have no backpressure; every in_valid=1 cycle not coinciding with rst SHALL be accepted.
REQ-022 All outputs SHALL be driven directly from registers, with no combinational path from inputs to outputs.

Reset
REQ-023 While rst=1 at a clock edge: S=0, D=0, is_negative=0, out_valid=0.
REQ-024 in_valid asserted in the same cycle as rst SHALL be discarded and produce no result.
REQ-025 If reset is asserted the cycle after an accept, it SHALL win; out_valid=0 and outputs clear.

Configuration
REQ-026 Macro MY_ADDER8_SUB_EN SHALL compile in the subtraction path.
REQ-027 With MY_ADDER8_SUB_EN defined, D and is_negative SHALL behave per REQ-014/015/017.
REQ-028 Without MY_ADDER8_SUB_EN, D and is_negative SHALL remain ports but be tied to constant 0, with no subtraction logic synthesized; S and out_valid SHALL be unaffected.

Verification (MY_ADDER8_SUB_EN defined unless stated)
REQ-029 A=0xFF, B=0xFF, in_valid 1 cycle -> next cycle: out_valid=1, S=0x1FE (510), D=0x00, is_negative=0.
REQ-030 A=0x05, B=0x0A -> S=0x00F, D=0x05, is_negative=1; A=0x0A, B=0x05 -> S=0x00F, D=0x05, is_negative=0.
REQ-031 A=0x80, B=0x80, then A=0x00, B=0xFF on consecutive cycles -> consecutive out_valid pulses with S=0x100 then S=0x0FF, and D=0x00/is_negative=0 then D=0xFF/is_negative=1.
REQ-032 Result S=0x1FE held, then in_valid=0 for 3 cycles -> S/D/is_negative unchanged, out_valid=0.
REQ-033 rst=1 together with in_valid=1 (A=0x12, B=0x34) -> next cycle all outputs 0, out_valid=0.
REQ-034 Macro undefined, A=0x03, B=0x07 -> S=0x00A, D=0, is_negative=0.
